cond_logic: RTL and testbench

- Stage directly downstream of the ALU and upstream of the register file, memory and PC write enables.
- Holds the architectural NZCV flags register and evaluates the instruction condition field against the stored flags.
- Gates the decoder's write requests (PCS, RegW, MemW, FlagW) so that failed-condition instructions have no architectural effect.
- Supports single-cycle mode (combinational CondEx) and multicycle mode (CondEx latched once per instruction).

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/cond_logic_if.sv | 31 +++
 rtl/cond_eval.sv | 41 ++++
 rtl/cond_logic.sv | 53 +++++
 tb/tb_cond_logic.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: ARM condition codes, NZCV flag bit
// positions and the split flag-write request bits.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/controller-facing bundle of the condition stage: write requests in,
// gated write enables and the architectural flags out.
interface cond_logic_if;

  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       CondLatch;

  logic [3:0] Flags;
  logic       CondEx;
  logic [1:0] FlagWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CondLatch,
    input  Flags, CondEx, FlagWrite, PCWrite, RegWrite, MemWrite
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CondLatch,
    output Flags, CondEx, FlagWrite, PCWrite, RegWrite, MemWrite
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV flag vector.
// Code 1111 never executes so the result is always a defined value.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       result
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    result = 1'b0;
    case (cond_e'(cond))
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~(c & ~z);
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = ~(~z & (n == v));
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition stage: holds NZCV, evaluates the instruction condition and gates
// the decoder's PC/register/memory/flag write requests with the outcome.
module cond_logic
  import cpu_ctrl_pkg::*;
#(
  parameter int MULTICYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [3:0] flagsq;
  logic       condexr;
  logic       evalresult;
  logic       condex;
  logic [1:0] flagwrite;

  cond_eval u_cond_eval (
    .cond   (bus.Cond),
    .flags  (flagsq),
    .result (evalresult)
  );

  // Multicycle mode freezes the decision at decode so later flag updates
  // within the same instruction cannot change its outcome.
  assign condex    = (MULTICYCLE != 0) ? condexr : evalresult;
  assign flagwrite = bus.FlagW & {2{condex}};

  // Evaluation sees the pre-update flags, so a same-edge latch and flag
  // write resolve against the old flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flagsq  <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      if (flagwrite[FW_NZ])
        flagsq[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (flagwrite[FW_CV])
        flagsq[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      if (bus.CondLatch)
        condexr <= evalresult;
    end
  end

  assign bus.Flags     = flagsq;
  assign bus.CondEx    = condex;
  assign bus.FlagWrite = flagwrite;
  assign bus.PCWrite   = bus.PCS & condex;
  assign bus.RegWrite  = bus.RegW & condex & ~bus.NoWrite;
  assign bus.MemWrite  = bus.MemW & condex;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic in multicycle mode: directed sequences,
// a condition table and random traffic against a behavioural flag model.
module tb_cond_logic;

  logic clk;
  logic reset;

  cond_logic_if bus ();

  cond_logic #(.MULTICYCLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared;
  int nMismatched;

  // Reference state: architectural flags and the decision taken at decode
  logic [3:0] mFlags;
  logic       mDecision;

  // Observation {Flags, CondEx, FlagWrite, PCWrite, RegWrite, MemWrite}
  logic [9:0] lastObs;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       expPass;
  } condVec_t;

  condVec_t table_q[$];

  // Condition semantics grouped by predicate pair; odd codes invert
  function automatic logic condTrue(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (code[3:1] == 3'd7) return (code[0] == 1'b0);
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ code[0];
  endfunction

  function automatic logic [9:0] expectedObs();
    logic d;
    d = mDecision;
    return {mFlags, d, bus.FlagW & {2{d}}, bus.PCS & d,
            bus.RegW & d & !bus.NoWrite, bus.MemW & d};
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] cond,
                               input logic [3:0] alu, input logic [1:0] fw,
                               input logic pcs, input logic regw,
                               input logic memw, input logic nw,
                               input logic latch);
    reset         = rst;
    bus.Cond      = cond;
    bus.ALUFlags  = alu;
    bus.FlagW     = fw;
    bus.PCS       = pcs;
    bus.RegW      = regw;
    bus.MemW      = memw;
    bus.NoWrite   = nw;
    bus.CondLatch = latch;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] got,
                             input logic [9:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b expected %b (Flags,CondEx,FlagWrite,PC,Reg,Mem)",
               name, got, want);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic checkFlags(input string name, input logic [3:0] got,
                            input logic [3:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: Flags got %b expected %b", name, got, want);
    end
  endtask

  // One cycle: drive, sample at negedge against the model, then advance it
  task automatic runCycle(input string name, input logic rst,
                          input logic [3:0] cond, input logic [3:0] alu,
                          input logic [1:0] fw, input logic pcs,
                          input logic regw, input logic memw,
                          input logic nw, input logic latch);
    logic d;
    applyStimulus(rst, cond, alu, fw, pcs, regw, memw, nw, latch);
    @(negedge clk);
    lastObs = {bus.Flags, bus.CondEx, bus.FlagWrite, bus.PCWrite,
               bus.RegWrite, bus.MemWrite};
    checkOutput(name, lastObs, expectedObs());
    @(posedge clk);
    if (rst) begin
      mFlags    = 4'b0000;
      mDecision = 1'b0;
    end else begin
      d = mDecision;
      if (latch) mDecision = condTrue(cond, mFlags);
      if (fw[1] && d) mFlags[3:2] = alu[3:2];
      if (fw[0] && d) mFlags[1:0] = alu[1:0];
    end
    #1;
  endtask

  // Load arbitrary flags: decode an AL instruction, then write all four flags
  task automatic loadFlags(input logic [3:0] f);
    runCycle("load_al", 1'b0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    runCycle("load_wr", 1'b0, 4'b1110, f,       2'b11, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    mFlags      = 4'b0000;
    mDecision   = 1'b0;

    table_q.push_back('{4'b1001, 4'b1010, 1'b1});
    table_q.push_back('{4'b1001, 4'b1100, 1'b1});
    table_q.push_back('{4'b1001, 4'b1011, 1'b0});
    table_q.push_back('{4'b1001, 4'b1101, 1'b0});
    table_q.push_back('{4'b1000, 4'b1010, 1'b0});
    table_q.push_back('{4'b1000, 4'b1011, 1'b1});
    table_q.push_back('{4'b0110, 4'b1000, 1'b0});
    table_q.push_back('{4'b0110, 4'b1001, 1'b1});
    table_q.push_back('{4'b0110, 4'b0000, 1'b1});
    table_q.push_back('{4'b0110, 4'b0001, 1'b0});
    table_q.push_back('{4'b0010, 4'b1000, 1'b1});
    table_q.push_back('{4'b0010, 4'b0010, 1'b1});
    table_q.push_back('{4'b0000, 4'b0011, 1'b1});
    table_q.push_back('{4'b1000, 4'b0100, 1'b1});
    table_q.push_back('{4'b1000, 4'b0101, 1'b0});
    table_q.push_back('{4'b0001, 4'b0110, 1'b1});
    table_q.push_back('{4'b0001, 4'b0111, 1'b0});
    table_q.push_back('{4'b0000, 4'b1110, 1'b1});
    table_q.push_back('{4'b0000, 4'b1111, 1'b0});
    table_q.push_back('{4'b0101, 4'b1100, 1'b0});
    table_q.push_back('{4'b0101, 4'b1101, 1'b1});

    // Reset with every write request and flag bit asserted
    applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    runCycle("reset", 1'b1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
    checkOutput("reset_const", lastObs, 10'b0000_0_00_0_0_0);

    // Nothing latched yet: all requests suppressed
    runCycle("nolatch1", 1'b0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    checkOutput("nolatch_const", lastObs, 10'b0000_0_00_0_0_0);
    runCycle("nolatch2", 1'b0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0, 0);

    // Flag set via AL then EQ
    runCycle("al_latch", 1'b0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 1);
    runCycle("al_write", 1'b0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
    checkBit("al_flagwrite", lastObs[4], 1'b1);
    runCycle("eq_latch", 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    checkFlags("flags_0100", lastObs[9:6], 4'b0100);
    runCycle("eq_exec", 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    checkBit("eq_condex", lastObs[5], 1'b1);
    checkBit("eq_regwrite", lastObs[1], 1'b1);

    // Failed NE: no PC, memory or flag write
    runCycle("ne_latch", 1'b0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    runCycle("ne_exec", 1'b0, 4'b0001, 4'b1000, 2'b11, 1, 0, 1, 0, 0);
    checkOutput("ne_blocked", lastObs, 10'b0100_0_00_0_0_0);
    runCycle("ne_after", 1'b0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    checkFlags("ne_flags_kept", lastObs[9:6], 4'b0100);

    // Partial flag write: only NZ
    loadFlags(4'b0000);
    runCycle("part_write", 1'b0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
    runCycle("part_after", 1'b0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    checkFlags("partial_1100", lastObs[9:6], 4'b1100);

    // Same-edge hazard: latch EQ against old flags while Z is being set
    loadFlags(4'b0000);
    runCycle("haz_edge", 1'b0, 4'b0000, 4'b0100, 2'b10, 0, 0, 0, 0, 1);
    runCycle("haz_after", 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    checkBit("hazard_condex", lastObs[5], 1'b0);
    checkFlags("hazard_flags", lastObs[9:6], 4'b0100);

    // Compare-class instruction never writes a register
    runCycle("cmp_latch", 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    runCycle("cmp_exec", 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 1, 0);
    checkBit("cmp_condex", lastObs[5], 1'b1);
    checkBit("nowrite_regwrite", lastObs[1], 1'b0);

    // Reset mid-instruction beats latch and flag write
    runCycle("midrst", 1'b1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
    runCycle("midrst_after", 1'b0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    checkOutput("midrst_const", lastObs, 10'b0000_0_00_0_0_0);

    // Condition table
    foreach (table_q[i]) begin
      loadFlags(table_q[i].flags);
      runCycle("tbl_latch", 1'b0, table_q[i].cond, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
      checkFlags($sformatf("tbl%0d_flags", i), lastObs[9:6], table_q[i].flags);
      runCycle("tbl_exec", 1'b0, table_q[i].cond, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
      checkBit($sformatf("tbl%0d_cond%b", i, table_q[i].cond), lastObs[5],
               table_q[i].expPass);
    end

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      runCycle("random", ($urandom_range(0, 49) == 0),
               4'($urandom), 4'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
